// File: rtl/muxn_pipe.sv
// muxn_pipe: registered N-way word selector with valid/ready handshaking.
// One output register stage; per-channel ready; direct selection via SEL.
// Optional round-robin arbitration is compiled in when the macro
// MUXN_RR_EN is defined (MODE=1 then selects round-robin). Without the
// macro, MODE is ignored and the block always runs in direct mode.
//
// Handshake rule (both sides): a word moves on a rising CLK edge exactly
// when valid and ready are both high in the cycle before that edge. A
// producer holds its data and valid until it sees ready; ready never
// depends on the same channel's own valid in direct mode.
module muxn_pipe #(
    parameter int WIDTH = 16,
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N*WIDTH-1:0] IN,
    input  logic [N-1:0]       IN_VALID,
    output logic [N-1:0]       IN_READY,
    input  logic [SEL_W-1:0]   SEL,
    input  logic               MODE,
    output logic [WIDTH-1:0]   OUT,
    output logic               OUT_VALID,
    output logic [SEL_W-1:0]   OUT_CHAN,
    input  logic               OUT_READY
);

    logic             load;
    logic             sel_in_range;
    logic             cand_ok;
    logic [SEL_W-1:0] cand;
    logic             transfer;
    logic [WIDTH-1:0] cap_data;

    // The output register can take a word when empty or being drained.
    // Held low during reset so no channel sees ready while RST_N=0.
    assign load         = RST_N && (!OUT_VALID || OUT_READY);
    assign sel_in_range = (32'(SEL) < 32'(N));

`ifdef MUXN_RR_EN
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] rr_cand;
    logic             rr_found;
    int               rr_dist;
    int               rr_best;

    // Round-robin scan: pick the valid channel with the smallest cyclic
    // distance from ptr, i.e. the first valid one scanning ptr..ptr+N-1.
    always_comb begin
        rr_best = N;
        rr_cand = '0;
        rr_dist = 0;
        for (int i = 0; i < N; i++) begin
            rr_dist = i - int'(ptr);
            if (rr_dist < 0) rr_dist = rr_dist + N;
            if (IN_VALID[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                rr_cand = SEL_W'(i);
            end
        end
    end

    assign rr_found = (rr_best < N);
    assign cand     = MODE ? rr_cand  : SEL;
    assign cand_ok  = MODE ? rr_found : sel_in_range;
    // Wrap explicitly so ptr never holds a value >= N for non-power-of-two N.
    assign ptr_next = (cand == SEL_W'(N - 1)) ? '0 : cand + 1'b1;

    // Pointer moves past the granted channel only on round-robin transfers;
    // it is retained across mode switches.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= '0;
        end else if (transfer && MODE) begin
            ptr <= ptr_next;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = MODE;
    assign cand        = SEL;
    assign cand_ok     = sel_in_range;
`endif

    // One-hot ready towards the candidate channel plus the data mux that
    // feeds the output register.
    always_comb begin
        IN_READY = '0;
        cap_data = '0;
        for (int i = 0; i < N; i++) begin
            if (load && cand_ok && (cand == SEL_W'(i))) begin
                IN_READY[i] = 1'b1;
                cap_data    = IN[i*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer = |(IN_VALID & IN_READY);

    // Output stage: capture on transfer, empty on load without transfer,
    // hold everything under backpressure.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            OUT_CHAN  <= '0;
        end else if (load) begin
            if (transfer) begin
                OUT       <= cap_data;
                OUT_CHAN  <= cand;
                OUT_VALID <= 1'b1;
            end else begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: directed bench for muxn_pipe with three instances
// (N=16, N=12, N=4; WIDTH=16). Round-robin checks are built when
// MUXN_RR_EN is defined.
module tb_muxn_pipe;

    logic clk;
    logic rst_n;

    // N=16 instance
    logic [16*16-1:0] in16;
    logic [15:0]      in_valid16, in_ready16;
    logic [3:0]       sel16, out_chan16;
    logic             mode16, out_valid16, out_ready16;
    logic [15:0]      out16;

    // N=12 instance
    logic [12*16-1:0] in12;
    logic [11:0]      in_valid12, in_ready12;
    logic [3:0]       sel12, out_chan12;
    logic             mode12, out_valid12, out_ready12;
    logic [15:0]      out12;

    // N=4 instance
    logic [4*16-1:0]  in4;
    logic [3:0]       in_valid4, in_ready4;
    logic [1:0]       sel4, out_chan4;
    logic             mode4, out_valid4, out_ready4;
    logic [15:0]      out4;

    int n_checks;
    int n_errors;

    muxn_pipe #(.WIDTH(16), .N(16)) u16 (
        .CLK(clk), .RST_N(rst_n), .IN(in16), .IN_VALID(in_valid16),
        .IN_READY(in_ready16), .SEL(sel16), .MODE(mode16), .OUT(out16),
        .OUT_VALID(out_valid16), .OUT_CHAN(out_chan16), .OUT_READY(out_ready16)
    );

    muxn_pipe #(.WIDTH(16), .N(12)) u12 (
        .CLK(clk), .RST_N(rst_n), .IN(in12), .IN_VALID(in_valid12),
        .IN_READY(in_ready12), .SEL(sel12), .MODE(mode12), .OUT(out12),
        .OUT_VALID(out_valid12), .OUT_CHAN(out_chan12), .OUT_READY(out_ready12)
    );

    muxn_pipe #(.WIDTH(16), .N(4)) u4 (
        .CLK(clk), .RST_N(rst_n), .IN(in4), .IN_VALID(in_valid4),
        .IN_READY(in_ready4), .SEL(sel4), .MODE(mode4), .OUT(out4),
        .OUT_VALID(out_valid4), .OUT_CHAN(out_chan4), .OUT_READY(out_ready4)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single checking task: counts and reports
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; return on the falling edge for sampling/driving
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef MUXN_RR_EN
    logic [1:0] rr_chan_seq [6];
    logic [1:0] rr_ptr_seq  [6];
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;

        for (int i = 0; i < 16; i++) in16[i*16 +: 16] = 16'h1000 + 16'(i);
        for (int i = 0; i < 12; i++) in12[i*16 +: 16] = 16'h3000 + 16'(i);
        for (int i = 0; i < 4; i++)  in4[i*16 +: 16]  = 16'h4000 + 16'(i);
        in_valid16 = '1; sel16 = 4'd5; mode16 = 1'b0; out_ready16 = 1'b1;
        in_valid12 = '1; sel12 = 4'd2; mode12 = 1'b0; out_ready12 = 1'b1;
        in_valid4  = '1; sel4  = 2'd0; mode4  = 1'b0; out_ready4  = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out",      out16,       16'h0);
        check("rst_valid",    out_valid16, 1'b0);
        check("rst_chan",     out_chan16,  4'd0);
        check("rst_ready16",  in_ready16,  16'h0);
        check("rst_ready4",   in_ready4,   4'h0);

        rst_n = 1'b1;
        #1;
        check("d_ready_pre", in_ready16, 16'h0020);

        // Direct mode, SEL=5
        tick();
        check("d_out",   out16,       16'h1005);
        check("d_chan",  out_chan16,  4'd5);
        check("d_valid", out_valid16, 1'b1);
        check("d_ready", in_ready16,  16'h0020);

        // Backpressure: hold for 3 cycles, then next word with no bubble
        out_ready16 = 1'b0;
        in16[5*16 +: 16] = 16'h2005;
        #1;
        check("bp_ready0", in_ready16, 16'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_out",   out16,       16'h1005);
            check("bp_valid", out_valid16, 1'b1);
            check("bp_ready", in_ready16,  16'h0);
        end
        out_ready16 = 1'b1;
        #1;
        check("bp_rel_ready", in_ready16, 16'h0020);
        tick();
        check("bp_next_out",   out16,       16'h2005);
        check("bp_next_valid", out_valid16, 1'b1);

        // Selection change and invalid selected channel
        sel16 = 4'd3;
        #1;
        check("s3_ready", in_ready16, 16'h0008);
        tick();
        check("s3_out",  out16,      16'h1003);
        check("s3_chan", out_chan16, 4'd3);
        in_valid16[3] = 1'b0;
        #1;
        check("inv_ready", in_ready16, 16'h0008);
        tick();
        check("inv_valid", out_valid16, 1'b0);
        check("inv_out",   out16,       16'h1003);
        check("inv_chan",  out_chan16,  4'd3);

        // Top channel boundary
        in_valid16 = '1;
        sel16 = 4'd15;
        #1;
        check("s15_ready", in_ready16, 16'h8000);
        tick();
        check("s15_out",  out16,      16'h100f);
        check("s15_chan", out_chan16, 4'd15);

        // N=12: out-of-range selection
        check("n12_out",   out12,       16'h3002);
        check("n12_valid", out_valid12, 1'b1);
        out_ready12 = 1'b0;
        sel12 = 4'd13;
        #1;
        check("oor_ready_bp", in_ready12, 12'h0);
        tick();
        check("oor_hold_valid", out_valid12, 1'b1);
        check("oor_hold_out",   out12,       16'h3002);
        out_ready12 = 1'b1;
        #1;
        check("oor_ready", in_ready12, 12'h0);
        tick();
        check("oor_drain_valid", out_valid12, 1'b0);
        check("oor_drain_out",   out12,       16'h3002);
        check("oor_drain_chan",  out_chan12,  4'd2);
        tick();
        check("oor_idle_valid", out_valid12, 1'b0);
        sel12 = 4'd11;
        #1;
        check("s11_ready", in_ready12, 12'h800);
        tick();
        check("s11_out",   out12,       16'h300b);
        check("s11_chan",  out_chan12,  4'd11);
        check("s11_valid", out_valid12, 1'b1);

        // N=4 direct
        sel4 = 2'd3;
        #1;
        check("n4_ready", in_ready4, 4'b1000);
        tick();
        check("n4_out",  out4,      16'h4003);
        check("n4_chan", out_chan4, 2'd3);

`ifndef MUXN_RR_EN
        // MODE is ignored without round-robin support
        mode4 = 1'b1;
        sel4  = 2'd1;
        #1;
        check("mode_ign_ready", in_ready4, 4'b0010);
        tick();
        check("mode_ign_out",  out4,      16'h4001);
        check("mode_ign_chan", out_chan4, 2'd1);
        mode4 = 1'b0;
`else
        // Round-robin over 4'b1011 starting at ptr=0
        rr_chan_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        rr_ptr_seq  = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        mode4     = 1'b1;
        in_valid4 = 4'b1011;
        #1;
        check("rr_ready0", in_ready4, 4'b0001);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_chan", out_chan4, rr_chan_seq[k]);
            check("rr_out",  out4,      16'h4000 + 16'(rr_chan_seq[k]));
            check("rr_ptr",  u4.ptr,    rr_ptr_seq[k]);
        end

        // Only channel 2 valid: reach ptr=3, then the scan wraps to 2
        in_valid4 = 4'b0100;
        tick();
        check("rr2_chan", out_chan4, 2'd2);
        check("rr2_ptr",  u4.ptr,    2'd3);
        #1;
        check("rr2_wrap_ready", in_ready4, 4'b0100);
        tick();
        check("rr2_wrap_chan", out_chan4, 2'd2);
        check("rr2_wrap_ptr",  u4.ptr,    2'd3);

        // Direct mode leaves ptr alone; switching back resumes from it
        mode4 = 1'b0;
        sel4  = 2'd0;
        in_valid4 = 4'b1111;
        tick();
        check("sw_chan", out_chan4, 2'd0);
        check("sw_ptr",  u4.ptr,    2'd3);
        mode4 = 1'b1;
        #1;
        check("sw_rr_ready", in_ready4, 4'b1000);
        tick();
        check("sw_rr_chan", out_chan4, 2'd3);
        check("sw_rr_ptr",  u4.ptr,    2'd0);

        // No valid channel: no candidate
        in_valid4 = 4'b0000;
        #1;
        check("rr_none_ready", in_ready4, 4'b0000);
        tick();
        check("rr_none_valid", out_valid4, 1'b0);

        // Leave ptr at 3 before the reset test
        in_valid4 = 4'b0100;
        tick();
        check("pre_rst_ptr", u4.ptr, 2'd3);
`endif

        // Asynchronous reset mid-cycle
        check("pre_rst_valid", out_valid16, 1'b1);
        #2;
        rst_n     = 1'b0;
        in_valid4 = 4'b1010;
        sel4      = 2'd1;
        #1;
        check("arst_out",    out16,       16'h0);
        check("arst_valid",  out_valid16, 1'b0);
        check("arst_chan",   out_chan16,  4'd0);
        check("arst_chan4",  out_chan4,   2'd0);
        check("arst_ready",  in_ready16,  16'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready4", in_ready4, 4'b0010);
        tick();
        check("post_rst_chan4", out_chan4, 2'd1);
        check("post_rst_out4",  out4,      16'h4001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised, registered N-way word selector with valid/ready handshaking. It generalises the fixed 16:1 × 16-bit combinational selector used in the single-cycle datapath. It adds configurable width and channel count, a one-stage output register, per-channel flow control and an optional round-robin arbitration mode. It sits between multiple producers (register-file ports, immediate/ALU result sources, or multi-cycle units) and a single pipelined consumer.

## Interface

- `WIDTH`, 16, data bits per channel.
- `N`, 16, channel count; any value 2–64, need not be a power of two.
- `SEL_W`, `$clog2(N)`, width of `SEL` and `OUT_CHAN`.

Ports:

- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `IN`  in  N*WIDTH  channel data, flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- `IN_VALID`  in  N  per-channel valid.
- `IN_READY`  out  N  per-channel ready; combinational.
- `SEL`  in  SEL_W  channel index, used in direct mode.
- `MODE`  in  1  0 = direct (`SEL`), 1 = round-robin (only with `MUXN_RR_EN`).
- `OUT`  out  WIDTH  registered data.
- `OUT_VALID`  out  1  registered valid.
- `OUT_CHAN`  out  SEL_W  channel index that produced `OUT`.
- `OUT_READY`  in  1  consumer ready.

## Operation

- `load = !OUT_VALID || OUT_READY`: the output register can accept a word this cycle.
- Candidate channel `c`:
  - Direct mode: `c = SEL`.
  - Round-robin mode: `c` is the first i with `IN_VALID[i]=1`, scanning cyclically from `PTR` through `PTR+N-1` mod N. If no channel is valid, there is no candidate.
- `IN_READY[i] = load && (i == c)`. At most one bit is high.
  - If `SEL >= N`, or there is no candidate, all `IN_READY` bits are 0.
- Transfer from channel c occurs when `IN_VALID[c] && IN_READY[c]`. On that edge: `OUT <= IN[c]`, `OUT_CHAN <= c`, `OUT_VALID <= 1`.
- When `load=1` and no transfer occurs: `OUT_VALID <= 0`. `OUT` and `OUT_CHAN` hold their values.
- When `load=0`: all output registers hold.
- `PTR` (internal, SEL_W bits):
  - Advances to `(c+1) mod N` on a transfer in round-robin mode only.
  - Wraps from N-1 to 0; never takes a value ≥ N.
  - Unchanged in direct mode.
- `MODE` and `SEL` are sampled combinationally every cycle. A switch takes effect on the same cycle, and `PTR` is retained across mode switches.

## Timing

- Reset state: `OUT=0`, `OUT_VALID=0`, `OUT_CHAN=0`, `PTR=0`. Consequently `IN_READY` is all-zero while `RST_N=0`.
- Reset asserted mid-transfer: the word being captured is discarded. Outputs reach the reset state asynchronously, independent of `CLK`.
- Latency: 1 cycle from input handshake to `OUT_VALID`.
- Throughput: 1 word/cycle while `OUT_READY=1`.
- Backpressure: while `OUT_VALID=1` and `OUT_READY=0`, `OUT`, `OUT_CHAN` and `OUT_VALID` are stable and all `IN_READY` bits are 0.
- Simultaneous output drain and input capture (`OUT_VALID=1`, `OUT_READY=1`, candidate valid): the new word replaces the old one with no bubble.
- `IN_READY` depends combinationally on `OUT_READY`, `SEL`, `MODE` and `IN_VALID`. No path exists from `IN`/`IN_VALID` to `OUT`/`OUT_VALID` without passing through the register.

## Configuration

- `MUXN_RR_EN` defined:
  - Round-robin logic and `PTR` are compiled in.
  - `MODE=1` selects round-robin arbitration.
- `MUXN_RR_EN` undefined:
  - The `MODE` port remains but is ignored; the block always runs in direct mode.
  - `PTR` and the scan logic are absent.
  - Behaviour is identical to `MODE=0` with the macro defined.

## Test plan

- Reset, then direct mode, N=16, WIDTH=16, `IN[i]=16'h1000+i`, all valid, `SEL=5`, `OUT_READY=1` → the cycle after the first edge shows `OUT=16'h1005`, `OUT_CHAN=5`, `OUT_VALID=1`; `IN_READY=16'h0020` throughout.
- Backpressure: `OUT_READY=0` for 3 cycles after a capture of `16'h1005` → `OUT` holds `16'h1005`, `IN_READY=0`. `OUT_READY=1` → the next word lands on the following edge with no bubble.
- Out-of-range selection, N=12, `SEL=13` → `IN_READY=0`, and `OUT_VALID` falls to 0 one cycle after the current word drains.
- Round-robin (`MUXN_RR_EN`), N=4, `IN_VALID=4'b1011` held, `OUT_READY=1` → `OUT_CHAN` sequence 0,1,3,0,1,3; `PTR` wraps from 3 to 0.
- Round-robin, only channel 2 valid, `PTR=3` → the scan wraps and grants channel 2; `PTR` becomes 3.
- Assert `RST_N=0` mid-cycle with `OUT_VALID=1` → `OUT`, `OUT_VALID` and `OUT_CHAN` go to 0 immediately, without waiting for a clock edge. After release, the first grant in round-robin mode goes to the lowest valid channel.
